// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the fifo_sync write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a requester index; never less than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 32'($clog2(n));
        return (w < 1) ? 1 : w;
    endfunction

    // Width of the per-grant beat counter.
    function automatic int unsigned beat_width(input int unsigned max_burst);
        return 32'($clog2(max_burst + 1));
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Round-robin priority search: first set request after rr_last, wrapping mod N_REQ.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   rr_last,
    output logic [IDW-1:0]   winner,
    output logic             any
);

    int unsigned idx;
    logic [IDW-1:0] idx_w;

    // Offsets start at 1 so the previous winner is examined last.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx   = (32'(rr_last) + i) % N_REQ;
            idx_w = IDW'(idx);
            if (!any && req[idx_w]) begin
                winner = idx_w;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo_sync write port among N_REQ producers.
// Optional FIFO_ARB_AF_THROTTLE_EN: end the burst on any beat written while almost_full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IDW      = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   fifo_full,
    input  logic                   fifo_almost_full,
    output logic                   fifo_write_en,
    output logic [WIDTH-1:0]       fifo_din,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy
);

    localparam int unsigned BW = beat_width(MAX_BURST);

    arb_state_t      state, state_n;
    logic [IDW-1:0]  grant_n;
    logic [IDW-1:0]  rr_last, rr_n;
    logic [BW-1:0]   beat_cnt, beat_n;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;
    logic            sel_valid;
    logic            xfer;
    logic            last_beat;
    logic            af_release;
    logic [WIDTH-1:0] slice [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign slice[g] = req_data[g*WIDTH +: WIDTH];
    end

`ifdef FIFO_ARB_AF_THROTTLE_EN
    assign af_release = fifo_almost_full;
`else
    logic unused_af;
    assign af_release = 1'b0;
    assign unused_af  = fifo_almost_full;
`endif

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req     (req_valid),
        .rr_last (rr_last),
        .winner  (pick_id),
        .any     (pick_any)
    );

    assign sel_valid = req_valid[grant_id];
    assign xfer      = (state == GRANT) && sel_valid && !fifo_full;
    assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));
    assign fifo_din  = slice[grant_id];

    // Next state and handshake outputs; write port is driven straight from the grant.
    always_comb begin
        state_n       = state;
        grant_n       = grant_id;
        rr_n          = rr_last;
        beat_n        = beat_cnt;
        req_ready     = '0;
        fifo_write_en = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_n = pick_id;
                    rr_n    = pick_id;
                    beat_n  = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_id] = !fifo_full;
                fifo_write_en       = xfer;
                if (!sel_valid) begin
                    state_n = IDLE;
                end else if (xfer) begin
                    if (last_beat || af_release) begin
                        state_n = IDLE;
                        beat_n  = '0;
                    end else begin
                        beat_n = beat_cnt + BW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_last  <= IDW'(N_REQ - 1);
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            grant_id <= grant_n;
            rr_last  <= rr_n;
            beat_cnt <= beat_n;
            busy     <= (state_n == GRANT);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small producer model and a write log.
module tb_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned MB = 4;
`ifdef FIFO_ARB_AF_THROTTLE_EN
    localparam int AFB    = 1;
    localparam int AF_CNT = 6;
`else
    localparam int AFB    = 4;
    localparam int AF_CNT = 9;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_almost_full;
    logic           fifo_write_en;
    logic [W-1:0]   fifo_din;
    logic [1:0]     grant_id;
    logic           busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_write_en    (fifo_write_en),
        .fifo_din         (fifo_din),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    int         n_vec;
    int         n_err;
    int         cyc;
    logic [7:0] data [N];
    int         rem  [N];
    int         log_id  [$];
    int         log_din [$];
    int         log_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] lg(input int kind, input int k);
        if (kind == 0) return (k < log_id.size())  ? 32'(log_id[k])  : 32'hFFFF_FFFF;
        if (kind == 1) return (k < log_din.size()) ? 32'(log_din[k]) : 32'hFFFF_FFFF;
        return (k < log_cyc.size()) ? 32'(log_cyc[k]) : 32'hFFFF_FFFF;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (rem[i] != 0);
            req_data[i*W +: W] = data[i];
        end
        #1;
    endtask

    // One clock: log the write, take the edge, advance producers that were accepted.
    task automatic tick();
        logic [N-1:0] acc;
        acc = req_valid & req_ready;
        if (fifo_write_en) begin
            log_id.push_back(int'(grant_id));
            log_din.push_back(int'(fifo_din));
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                data[i] = data[i] + 8'd1;
                rem[i]--;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            data[i] = 8'h00;
        end
        drive();
        tick();
        tick();
        rst_n = 1'b1;
        log_id.delete();
        log_din.delete();
        log_cyc.delete();
        cyc = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        req_valid = '0;
        req_data  = '0;
        do_reset();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we", 32'(fifo_write_en), 32'd0);

        // Single requester: two full bursts separated by one bubble
        data[0] = 8'h10;
        rem[0]  = 8;
        drive();
        chk("t1_latency_ready", 32'(req_ready), 32'd0);
        tick();
        chk("t1_grant", 32'(grant_id), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(req_ready), 32'h1);
        repeat (11) tick();
        chk("t1_count", 32'(log_din.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("t1_din", lg(1, k), 32'(8'h10 + k));
            chk("t1_cyc", lg(2, k), 32'(1 + (k / 4) * 5 + k % 4));
        end

        // All requesters continuously valid: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) begin
            data[i] = 8'(8'h40 + 16 * i);
            rem[i]  = 100;
        end
        drive();
        repeat (25) tick();
        chk("t2_count", 32'(log_din.size()), 32'd20);
        for (int k = 0; k < 20; k++) begin
            chk("t2_id", lg(0, k), 32'((k / 4) % 4));
            chk("t2_din", lg(1, k), 32'(8'h40 + 16 * ((k / 4) % 4) + (k / 16) * 4 + k % 4));
            chk("t2_cyc", lg(2, k), 32'(1 + (k / 4) * 5 + k % 4));
        end

        // Full stall mid-burst on requester 2
        do_reset();
        data[2] = 8'h30;
        rem[2]  = 4;
        drive();
        tick();
        chk("t3_grant", 32'(grant_id), 32'd2);
        tick();
        tick();
        fifo_full = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("t3_full_ready", 32'(req_ready), 32'd0);
            chk("t3_full_we", 32'(fifo_write_en), 32'd0);
            chk("t3_full_grant", 32'(grant_id), 32'd2);
            chk("t3_full_busy", 32'(busy), 32'd1);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        chk("t3_resume_ready", 32'(req_ready), 32'h4);
        tick();
        tick();
        chk("t3_release", 32'(busy), 32'd0);
        chk("t3_count", 32'(log_din.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t3_din", lg(1, k), 32'(8'h30 + k));
            chk("t3_cyc", lg(2, k), (k < 2) ? 32'(1 + k) : 32'(4 + k));
        end

        // Requester 1 drops valid after 2 beats; it becomes lowest priority
        do_reset();
        data[1] = 8'h50;
        rem[1]  = 2;
        data[3] = 8'h70;
        rem[3]  = 2;
        drive();
        tick();
        chk("t4_grant", 32'(grant_id), 32'd1);
        data[0] = 8'h60;
        rem[0]  = 2;
        drive();
        tick();
        tick();
        chk("t4_drop_we", 32'(fifo_write_en), 32'd0);
        tick();
        rem[1] = 2;
        drive();
        repeat (13) tick();
        chk("t4_count", 32'(log_din.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] eid;
            logic [31:0] edin;
            case (k / 2)
                0:       begin eid = 32'd1; edin = 32'(8'h50 + k);       end
                1:       begin eid = 32'd3; edin = 32'(8'h70 + k - 2);   end
                2:       begin eid = 32'd0; edin = 32'(8'h60 + k - 4);   end
                default: begin eid = 32'd1; edin = 32'(8'h52 + k - 6);   end
            endcase
            chk("t4_id", lg(0, k), eid);
            chk("t4_din", lg(1, k), edin);
        end

        // Reset during beat 2 of a grant to requester 2
        do_reset();
        data[2] = 8'h80;
        rem[2]  = 8;
        drive();
        tick();
        tick();
        chk("t5_pre_we", 32'(fifo_write_en), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd0);
        chk("t5_we", 32'(fifo_write_en), 32'd0);
        chk("t5_grant", 32'(grant_id), 32'd0);
        rst_n   = 1'b1;
        rem[2]  = 0;
        data[0] = 8'h90;
        rem[0]  = 4;
        data[3] = 8'hA0;
        rem[3]  = 4;
        drive();
        tick();
        chk("t5_first_grant", 32'(grant_id), 32'd0);
        chk("t5_first_busy", 32'(busy), 32'd1);

        // almost_full held high from the first beat
        do_reset();
        fifo_almost_full = 1'b1;
        data[0] = 8'hC0;
        rem[0]  = 100;
        data[1] = 8'hD0;
        rem[1]  = 100;
        drive();
        repeat (12) tick();
        chk("t6_count", 32'(log_din.size()), 32'(AF_CNT));
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k / AFB;
            chk("t6_id", lg(0, k), 32'(g % 2));
            chk("t6_din", lg(1, k), 32'(((g % 2) == 0 ? 8'hC0 : 8'hD0) + (g / 2) * AFB + k % AFB));
            chk("t6_cyc", lg(2, k), 32'(1 + g * (AFB + 1) + k % AFB));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
